// File: rtl/icache_pkg.sv
// Shared ICache types: line geometry, fill FSM states and the line-buffer write port.
package icache_pkg;
  localparam int LINE_W         = 128;
  localparam int WORD_W         = 32;
  localparam int WORDS_PER_LINE = 4;
  localparam int OFFSET_W       = 4;
  localparam int SET_W          = 4;
  localparam int IDX_W          = $clog2(WORDS_PER_LINE);

  typedef logic [LINE_W-1:0] line_t;

  typedef enum logic [1:0] {IDLE, WAIT, READ, RESP} fill_state_t;

  typedef struct packed {
    logic              en;
    logic [IDX_W-1:0]  idx;
    logic [WORD_W-1:0] data;
  } word_wr_t;
endpackage

// File: rtl/icache_line_server_line_buf.sv
// Line assembly buffer: one indexed word write per cycle, full line read-out.
module line_buf
  import icache_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  word_wr_t wr,
  output line_t    line
);
  logic [WORDS_PER_LINE-1:0][WORD_W-1:0] words;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       words         <= '0;
    else if (wr.en)  words[wr.idx] <= wr.data;
  end

  // word k lands at bits [32k+31:32k]
  assign line = words;
endmodule

// File: rtl/icache_line_server.sv
// ICache refill responder: optional latency wait, four word reads, line handed back via valid/ready.
module icache_line_server
  import icache_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output line_t             dline,
  output logic              busy
);
  localparam logic [3:0]        WAIT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
  localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'(2**OFFSET_W - 1);

  fill_state_t       state, state_d;
  logic [3:0]        wcnt;
  logic [2:0]        cnt;
  logic [ADDR_W-1:0] line_addr, addr_q, rd_addr;
  word_wr_t          wr;

  // offset add stays inside the line; carry-out past ADDR_W is dropped
  assign rd_addr  = line_addr + {{(ADDR_W-4){1'b0}}, cnt[1:0], 2'b00};
  assign mem_addr = mem_en ? rd_addr : addr_q;

  always_comb begin
    state_d    = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    busy       = 1'b1;
    mem_en     = 1'b0;
    wr         = '0;
    wr.data    = mem_rdata;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) state_d = (LATENCY > 0) ? WAIT : READ;
      end
      WAIT: if (wcnt == 4'd0) state_d = READ;
      READ: begin
        // read issued at cnt, data returns and is stored at cnt+1
        mem_en = (cnt != 3'd4);
        wr.en  = (cnt != 3'd0);
        wr.idx = cnt[1:0] - 2'd1;
        if (cnt == 3'd4) state_d = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      wcnt      <= '0;
      cnt       <= '0;
      line_addr <= '0;
      addr_q    <= '0;
    end else begin
      state <= state_d;
      case (state)
        IDLE: if (req_valid) begin
          line_addr <= req_addr & ~OFF_MASK;
          wcnt      <= WAIT_LOAD;
        end
        WAIT: if (wcnt != 4'd0) wcnt <= wcnt - 4'd1;
        READ: cnt <= (cnt == 3'd4) ? 3'd0 : cnt + 3'd1;
        default: ;
      endcase
      if (mem_en) addr_q <= rd_addr;
    end
  end

  line_buf u_line_buf (
    .clk   (clk),
    .reset (reset),
    .wr    (wr),
    .line  (dline)
  );
endmodule

// File: tb/tb_icache_line_server.sv
// Bench for icache_line_server: table of fills on a LATENCY=2 instance, a LATENCY=0 instance, random fills, mid-fill reset.
module tb_icache_line_server;
  import icache_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        req_valid [2];
  logic [31:0] req_addr  [2];
  logic        req_ready [2];
  logic        mem_en    [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_rdata [2] = '{32'h0, 32'h0};
  logic        resp_valid[2];
  logic        resp_ready[2];
  line_t       dline     [2];
  logic        busy      [2];

  icache_line_server #(.LATENCY(2), .ADDR_W(32)) u_l2 (
    .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_addr(req_addr[0]),
    .req_ready(req_ready[0]), .mem_en(mem_en[0]), .mem_addr(mem_addr[0]),
    .mem_rdata(mem_rdata[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .dline(dline[0]), .busy(busy[0]));

  icache_line_server #(.LATENCY(0), .ADDR_W(32)) u_l0 (
    .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_addr(req_addr[1]),
    .req_ready(req_ready[1]), .mem_en(mem_en[1]), .mem_addr(mem_addr[1]),
    .mem_rdata(mem_rdata[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .dline(dline[1]), .busy(busy[1]));

  // instruction memory contents: a few fixed words, a hash of the address elsewhere
  function automatic logic [31:0] word_at(logic [31:0] a);
    case (a)
      32'h00400020: return 32'h11111111;
      32'h00400024: return 32'h22222222;
      32'h00400028: return 32'h33333333;
      32'h0040002C: return 32'h44444444;
      32'hFFFFFFF0: return 32'hCAFE0000;
      32'hFFFFFFF4: return 32'hCAFE0004;
      32'hFFFFFFF8: return 32'hCAFE0008;
      32'hFFFFFFFC: return 32'hCAFE000C;
      default:      return {a[15:0], ~a[31:16]} ^ 32'h13579BDF;
    endcase
  endfunction

  always @(posedge clk) if (mem_en[0]) mem_rdata[0] <= word_at(mem_addr[0]);
  always @(posedge clk) if (mem_en[1]) mem_rdata[1] <= word_at(mem_addr[1]);

  function automatic line_t model_line(logic [31:0] addr);
    logic [31:0] b;
    b = addr & 32'hFFFFFFF0;
    return {word_at(b + 32'd12), word_at(b + 32'd8), word_at(b + 32'd4), word_at(b)};
  endfunction

  int checks = 0;
  int failures = 0;

  task automatic chk(string nm, logic [127:0] got, logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic chk_reset_vals(int s, string tag);
    chk($sformatf("%s s%0d req_ready", tag, s), 128'(req_ready[s]), 128'(1));
    chk($sformatf("%s s%0d resp_valid", tag, s), 128'(resp_valid[s]), 128'(0));
    chk($sformatf("%s s%0d mem_en", tag, s), 128'(mem_en[s]), 128'(0));
    chk($sformatf("%s s%0d mem_addr", tag, s), 128'(mem_addr[s]), 128'(0));
    chk($sformatf("%s s%0d dline", tag, s), dline[s], 128'(0));
    chk($sformatf("%s s%0d busy", tag, s), 128'(busy[s]), 128'(0));
  endtask

  // Called on the falling edge of the acceptance cycle (cycle 0); returns on the
  // falling edge of the first IDLE cycle after the handshake.
  task automatic run_fill(int s, int lat, logic [31:0] addr, int stall, line_t exp,
                          bit hold, bit poke);
    logic [31:0] base;
    int t_resp, t_done;
    bit exp_en, in_resp;
    base   = addr & 32'hFFFFFFF0;
    t_resp = 6 + lat;
    t_done = t_resp + stall;
    chk($sformatf("s%0d accept ready @%h", s, addr), 128'(req_ready[s]), 128'(1));
    req_valid[s]  = 1'b1;
    req_addr[s]   = addr;
    resp_ready[s] = 1'b0;
    for (int k = 1; k <= t_done + 1; k++) begin
      @(negedge clk);
      if (poke && k == 2 + lat) begin
        req_valid[s] = 1'b1;
        req_addr[s]  = 32'h00000100;
      end else begin
        req_valid[s] = hold;
        req_addr[s]  = addr;
      end
      exp_en  = (k >= 1 + lat) && (k <= 4 + lat);
      in_resp = (k >= t_resp) && (k <= t_done);
      chk($sformatf("s%0d mem_en c%0d", s, k), 128'(mem_en[s]), 128'(exp_en));
      if (exp_en)
        chk($sformatf("s%0d mem_addr c%0d", s, k), 128'(mem_addr[s]),
            128'(base + 32'(4 * (k - 1 - lat))));
      else if (k > 4 + lat)
        chk($sformatf("s%0d mem_addr hold c%0d", s, k), 128'(mem_addr[s]), 128'(base + 32'd12));
      chk($sformatf("s%0d resp_valid c%0d", s, k), 128'(resp_valid[s]), 128'(in_resp));
      chk($sformatf("s%0d busy c%0d", s, k), 128'(busy[s]), 128'(k <= t_done));
      chk($sformatf("s%0d req_ready c%0d", s, k), 128'(req_ready[s]), 128'(k > t_done));
      if (in_resp) chk($sformatf("s%0d dline c%0d", s, k), dline[s], exp);
      resp_ready[s] = (k == t_done);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    int          stall;
    bit          hold;
    bit          poke;
    line_t       exp;
  } vec_t;

  localparam line_t L_BASIC = 128'h44444444_33333333_22222222_11111111;
  localparam line_t L_WRAP  = 128'hCAFE000C_CAFE0008_CAFE0004_CAFE0000;

  initial begin
    vec_t vt[6];
    vt[0] = '{32'h00400024, 0, 1'b0, 1'b0, L_BASIC};  // basic fill
    vt[1] = '{32'h00400028, 5, 1'b0, 1'b0, L_BASIC};  // 5 cycles of backpressure
    vt[2] = '{32'hFFFFFFFC, 0, 1'b0, 1'b0, L_WRAP};   // top-of-memory line
    vt[3] = '{32'h0040002C, 1, 1'b0, 1'b1, L_BASIC};  // stray pulse during READ
    vt[4] = '{32'h00400020, 2, 1'b1, 1'b0, L_BASIC};  // request held across response
    vt[5] = '{32'hFFFFFFF0, 0, 1'b0, 1'b0, L_WRAP};   // the held request, taken at once

    for (int s = 0; s < 2; s++) begin
      req_valid[s] = 1'b0; req_addr[s] = '0; resp_ready[s] = 1'b0;
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_vals(0, "por");
    chk_reset_vals(1, "por");
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++)
      run_fill(0, 2, vt[i].addr, vt[i].stall, vt[i].exp, vt[i].hold, vt[i].poke);

    run_fill(1, 0, 32'h00400024, 0, L_BASIC, 1'b0, 1'b0);
    run_fill(1, 0, 32'hFFFFFFFC, 3, L_WRAP, 1'b0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      logic [31:0] a;
      int s;
      s = i % 2;
      a = $urandom;
      run_fill(s, (s == 0) ? 2 : 0, a, int'($urandom_range(0, 3)), model_line(a), 1'b0, 1'b0);
    end

    // reset while READ is at cnt=2 on the LATENCY=2 instance
    req_valid[0] = 1'b1;
    req_addr[0]  = 32'h00400020;
    @(negedge clk);
    req_valid[0] = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst pre mem_en", 128'(mem_en[0]), 128'(1));
    chk("midrst pre mem_addr", 128'(mem_addr[0]), 128'(32'h00400028));
    #2 reset = 1'b1;
    #1 chk_reset_vals(0, "midrst");
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("post-rst resp_valid c%0d", k), 128'(resp_valid[0]), 128'(0));
      chk($sformatf("post-rst busy c%0d", k), 128'(busy[0]), 128'(0));
    end
    run_fill(0, 2, 32'h00400024, 0, L_BASIC, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/icache_line_server.md
Name: icache_line_server

Overview:
- Memory-side responder for instruction-cache line refills.
- Accepts one line-fill request at a time from the ICache miss path.
- Waits a programmable access latency, then reads the four 32-bit words of the line from a word-wide instruction memory port with 1-cycle read latency.
- Packs the words into a 128-bit line and presents it to the cache as dline under a valid/ready handshake.

Parameters:
- LATENCY, 2, extra wait cycles between request acceptance and the first memory read; legal range 0..15.
- ADDR_W, 32, byte-address width.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  cache requests a line fill.
- req_addr  input  ADDR_W  miss address; bits [3:0] are ignored.
- req_ready  output  1  block can accept a request.
- mem_en  output  1  word read strobe to instruction memory.
- mem_addr  output  ADDR_W  word byte-address being read.
- mem_rdata  input  32  read data, valid the cycle after mem_en.
- resp_valid  output  1  dline holds a complete line.
- resp_ready  input  1  cache consumes the line.
- dline  output  128  filled line; word k at bits [32k+31:32k].
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Clock and reset are fixed: one clock, clk; reset is asynchronous and active-high, named reset.
- Reset values: FSM=IDLE, req_ready=1, resp_valid=0, mem_en=0, mem_addr=0, dline=0, busy=0, counters=0.
- Reset asserted mid-operation aborts the fill immediately. No partial line is ever presented.
- States:
  - IDLE: req_ready=1. On req_valid, latch line_addr={req_addr[31:4],4'b0}. Go to WAIT if LATENCY>0, otherwise go to READ.
  - WAIT: req_ready=0. Wait counter loads LATENCY−1 on entry and decrements each cycle. When it is 0, go to READ.
  - READ: runs exactly 5 cycles, cnt=0..4.
    - When cnt<4: mem_en=1 and mem_addr=line_addr+4*cnt.
    - When cnt>0: capture mem_rdata into word cnt−1 of the line buffer.
    - After cnt=4, go to RESP.
  - RESP: resp_valid=1 and dline is held stable. When resp_ready=1, return to IDLE.
- Timing: request accepted in cycle 0 gives resp_valid first high in cycle 6+LATENCY.
- If resp_ready is high in the first RESP cycle, the transfer completes that cycle and IDLE follows. Next acceptance is at the earliest in the following cycle; there is no IDLE bypass.
- req_valid is ignored outside IDLE. A request held high across a response is accepted again once IDLE is reached.
- mem_addr wraps modulo 2^ADDR_W. With line_addr=0xFFFFFFF0, the reads are 0xFFFFFFF0, 0xFFFFFFF4, 0xFFFFFFF8 and 0xFFFFFFFC; there is no carry into other lines.
- dline keeps the last line after the handshake until the next fill overwrites it word by word. Consumers sample dline only while resp_valid=1.
- mem_addr holds its last value whenever mem_en=0.

Decomposition:
- Shared package icache_pkg:
  - constants LINE_W=128, WORD_W=32, WORDS_PER_LINE=4, OFFSET_W=4, SET_W=4;
  - typedef line_t (logic[127:0]);
  - enum fill_state_t {IDLE, WAIT, READ, RESP}.
- ICache uses the same package for its dline port.
- One sub-module is natural: line_buf. It is a 4×32 register with an indexed word write and the full 128-bit read-out, reset to 0.

Test Plan:
- Basic fill, LATENCY=2.
  - Stimulus: req at 0x00400024; memory words 0x11111111, 0x22222222, 0x33333333, 0x44444444 at 0x00400020..2C; resp_ready held high.
  - Required: mem_addr 0x00400020..2C in cycles 3..6, resp_valid in cycle 8 only, dline=0x44444444_33333333_22222222_11111111.
- LATENCY=0.
  - Stimulus: same request as the basic fill.
  - Required: mem_en high in cycles 1..4, resp_valid in cycle 6.
- Backpressure.
  - Stimulus: resp_ready=0 for 5 cycles, then 1.
  - Required: resp_valid and dline stable all 5 cycles, req_ready=0 throughout, IDLE one cycle after the handshake.
- Request during fill.
  - Stimulus: a second req_valid pulse to 0x00000100 while in READ.
  - Required: the pulse is ignored and only one response is produced. A held request is accepted in the first IDLE cycle after the response.
- Address wrap.
  - Stimulus: req_addr=0xFFFFFFFC.
  - Required: reads at 0xFFFFFFF0, 0xFFFFFFF4, 0xFFFFFFF8, 0xFFFFFFFC.
- Reset mid-fill.
  - Stimulus: assert reset in READ at cnt=2, asynchronously off a clock edge.
  - Required: outputs return to reset values immediately, no resp_valid afterwards, a new request fills correctly.
